// File: rtl/pc_unit.sv
// Program-counter / next-PC unit: holds the architectural PC, selects the successor,
// supports stall, halts on a misaligned register jump and counts retired/redirected updates.
module pc_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       npc_sel,
   input  logic             branch_cond,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             redirect,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'b00,
      SEL_BRANCH = 2'b01,
      SEL_JUMP   = 2'b10,
      SEL_JR     = 2'b11
   } npc_sel_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   state_e      state;
   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;
   logic [31:0] next_pc;
   logic        taken;
   logic        misaligned;

   assign pc_plus4   = pc + 32'd4;
   assign branch_tgt = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign jump_tgt   = {pc_plus4[31:28], instr_index, 2'b00};
   assign misaligned = (npc_sel_e'(npc_sel) == SEL_JR) && (jr_target[1:0] != 2'b00);

   // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      next_pc = pc_plus4;
      taken   = 1'b0;
      case (npc_sel_e'(npc_sel))
         SEL_SEQ: begin
            next_pc = pc_plus4;
            taken   = 1'b0;
         end
         SEL_BRANCH: begin
            next_pc = branch_cond ? branch_tgt : pc_plus4;
            taken   = branch_cond;
         end
         SEL_JUMP: begin
            next_pc = jump_tgt;
            taken   = 1'b1;
         end
         SEL_JR: begin
            next_pc = jr_target;
            taken   = 1'b1;
         end
         default: begin
            next_pc = pc_plus4;
            taken   = 1'b0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         pc        <= PC_RESET;
         redirect  <= 1'b0;
         halted    <= 1'b0;
         instr_cnt <= '0;
         taken_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (stall) begin
                  redirect <= 1'b0;
               end else if (misaligned) begin
                  // The faulting jr does not retire: pc and counters keep their values.
                  state    <= ST_HALTED;
                  halted   <= 1'b1;
                  redirect <= 1'b0;
               end else begin
                  pc        <= next_pc;
                  instr_cnt <= instr_cnt + CNT_W'(1);
                  redirect  <= taken;
                  taken_cnt <= taken_cnt + CNT_W'(taken);
               end
            end
            ST_HALTED: begin
               redirect <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state    <= ST_HALTED;
               redirect <= 1'b0;
               halted   <= 1'b1;
            end
         endcase
      end
   end

endmodule
